// File: rtl/k_and_s_pkg.sv
// rtl/k_and_s_pkg.sv - K&S 16-bit processor shared types, opcodes and ALU op codes
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
        I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
    } decoded_instruction_type;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_BRANCH = 8'h01;
    localparam logic [7:0] OP_BZERO  = 8'h02;
    localparam logic [7:0] OP_BNZERO = 8'h03;
    localparam logic [7:0] OP_BNEG   = 8'h04;
    localparam logic [7:0] OP_BNNEG  = 8'h05;
    localparam logic [7:0] OP_BOV    = 8'h06;
    localparam logic [7:0] OP_BNOV   = 8'h07;
    localparam logic [7:0] OP_LOAD   = 8'h81;
    localparam logic [7:0] OP_STORE  = 8'h82;
    localparam logic [7:0] OP_MOVE   = 8'h91;
    localparam logic [7:0] OP_ADD    = 8'hA1;
    localparam logic [7:0] OP_SUB    = 8'hA2;
    localparam logic [7:0] OP_AND    = 8'hA3;
    localparam logic [7:0] OP_OR     = 8'hA4;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    function automatic decoded_instruction_type decode_opcode(input logic [7:0] opcode);
        case (opcode)
            OP_BRANCH: return I_BRANCH;
            OP_BZERO:  return I_BZERO;
            OP_BNZERO: return I_BNZERO;
            OP_BNEG:   return I_BNEG;
            OP_BNNEG:  return I_BNNEG;
            OP_BOV:    return I_BOV;
            OP_BNOV:   return I_BNOV;
            OP_LOAD:   return I_LOAD;
            OP_STORE:  return I_STORE;
            OP_MOVE:   return I_MOVE;
            OP_ADD:    return I_ADD;
            OP_SUB:    return I_SUB;
            OP_AND:    return I_AND;
            OP_OR:     return I_OR;
            OP_HALT:   return I_HALT;
            default:   return I_NOP;
        endcase
    endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 4x16 register file, two async read ports, one sync write port
module register_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [1:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [1:0]  rd_a_addr,
    output logic [15:0] rd_a_data,
    input  logic [1:0]  rd_b_addr,
    output logic [15:0] rd_b_data
);

    logic [15:0] regs [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '{default: 16'h0000};
        end else if (we) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // No write-to-read bypass: readers see the pre-edge value.
    assign rd_a_data = regs[rd_a_addr];
    assign rd_b_data = regs[rd_b_addr];

endmodule

// File: rtl/data_path.sv
// rtl/data_path.sv - K&S execution datapath: PC, IR, decoder, register file, ALU, flags
module data_path
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [4:0]              ram_addr,
    output logic [15:0]             data_out,
    input  logic [15:0]             data_in
);

    logic [4:0]  pc;
    logic [15:0] ir;
    logic [1:0]  a_addr, b_addr, c_addr;
    logic [15:0] a_data, b_data, alu_result, c_data;
    logic [16:0] sum17, diff17;
    logic        alu_uovf, alu_sovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= 5'd0;
            ir <= 16'h0000;
        end else begin
            if (ir_enable) ir <= data_in;
            // A fetch with branch=1 jumps to the target held in the old IR.
            if (pc_enable) pc <= branch ? ir[4:0] : pc + 5'd1;
        end
    end

    assign decoded_instruction = decode_opcode(ir[15:8]);

    always_comb begin
        a_addr = 2'd0;
        b_addr = 2'd0;
        c_addr = 2'd0;
        case (decoded_instruction)
            I_LOAD:  c_addr = ir[6:5];
            I_STORE: a_addr = ir[6:5];
            I_MOVE: begin
                c_addr = ir[3:2];
                a_addr = ir[1:0];
                b_addr = ir[1:0];
            end
            I_ADD, I_SUB, I_AND, I_OR: begin
                c_addr = ir[5:4];
                a_addr = ir[3:2];
                b_addr = ir[1:0];
            end
            default: ;
        endcase
    end

    register_file u_register_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (write_reg_enable),
        .wr_addr   (c_addr),
        .wr_data   (c_data),
        .rd_a_addr (a_addr),
        .rd_a_data (a_data),
        .rd_b_addr (b_addr),
        .rd_b_data (b_data)
    );

    assign sum17  = {1'b0, a_data} + {1'b0, b_data};
    assign diff17 = {1'b0, a_data} - {1'b0, b_data};

    always_comb begin
        alu_result = 16'h0000;
        alu_uovf   = 1'b0;
        alu_sovf   = 1'b0;
        case (operation)
            ALU_ADD: begin
                alu_result = sum17[15:0];
                alu_uovf   = sum17[16];
                alu_sovf   = (a_data[15] == b_data[15]) && (sum17[15] != a_data[15]);
            end
            ALU_SUB: begin
                alu_result = diff17[15:0];
                alu_uovf   = diff17[16];
                alu_sovf   = (a_data[15] != b_data[15]) && (diff17[15] != a_data[15]);
            end
            ALU_AND: alu_result = a_data & b_data;
            default: alu_result = a_data | b_data;
        endcase
    end

    assign c_data = c_sel ? alu_result : data_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
        end else if (flags_reg_enable) begin
            zero_op           <= (alu_result == 16'h0000);
            neg_op            <= alu_result[15];
            unsigned_overflow <= alu_uovf;
            signed_overflow   <= alu_sovf;
        end
    end

    assign ram_addr = addr_sel ? ir[4:0] : pc;
    assign data_out = a_data;

endmodule

// File: tb/tb_data_path.sv
// tb/tb_data_path.sv - scoreboard testbench for data_path
module tb_data_path;
    import k_and_s_pkg::*;

    localparam int K_ADDR = 0, K_DOUT = 1, K_DEC = 2, K_ZERO = 3, K_NEG = 4, K_UOVF = 5, K_SOVF = 6;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, flags_reg_enable;
    logic [1:0] operation;
    logic [15:0] data_in, data_out;
    logic [4:0] ram_addr;
    logic zero_op, neg_op, unsigned_overflow, signed_overflow;
    decoded_instruction_type decoded_instruction;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    data_path dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .write_reg_enable    (write_reg_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .flags_reg_enable    (flags_reg_enable),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .ram_addr            (ram_addr),
        .data_out            (data_out),
        .data_in             (data_in)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] actual(input int kind);
        case (kind)
            K_ADDR:  return {11'd0, ram_addr};
            K_DOUT:  return data_out;
            K_DEC:   return {12'd0, decoded_instruction};
            K_ZERO:  return {15'd0, zero_op};
            K_NEG:   return {15'd0, neg_op};
            K_UOVF:  return {15'd0, unsigned_overflow};
            default: return {15'd0, signed_overflow};
        endcase
    endfunction

    // Monitor: outputs are sampled 2 time units after each falling edge.
    always @(negedge clk) begin
        #2;
        while (sb.size() > 0) begin
            exp_t e;
            logic [15:0] act;
            e = sb.pop_front();
            act = actual(e.kind);
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic push(input string name, input int kind, input logic [15:0] exp);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic push_flags(input string tag, input logic z, input logic n, input logic u, input logic s);
        push({tag, "_zero"}, K_ZERO, {15'd0, z});
        push({tag, "_neg"},  K_NEG,  {15'd0, n});
        push({tag, "_uovf"}, K_UOVF, {15'd0, u});
        push({tag, "_sovf"}, K_SOVF, {15'd0, s});
    endtask

    task automatic idle();
        branch = 0; pc_enable = 0; ir_enable = 0; write_reg_enable = 0;
        addr_sel = 0; c_sel = 0; operation = 2'b00; flags_reg_enable = 0; data_in = 16'h0000;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic load_ir(input logic [15:0] w);
        step();
        ir_enable = 1;
        data_in   = w;
    endtask

    task automatic write_reg(input logic [1:0] r, input logic [15:0] v);
        load_ir(16'h8100 | (16'(r) << 5));
        step();
        addr_sel = 1; write_reg_enable = 1; data_in = v;
    endtask

    task automatic expect_reg(input string name, input logic [1:0] r, input logic [15:0] v);
        load_ir(16'h8200 | (16'(r) << 5));
        step();
        push(name, K_DOUT, v);
    endtask

    task automatic alu_op(input logic [15:0] instr, input logic [1:0] op);
        load_ir(instr);
        step();
        c_sel = 1; write_reg_enable = 1; operation = op; flags_reg_enable = 1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        @(negedge clk);
        push("rst_addr", K_ADDR, 16'h0000);
        push("rst_dout", K_DOUT, 16'h0000);
        push("rst_dec",  K_DEC,  16'(I_NOP));
        push_flags("rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1;

        // Fetch: IR <= 8103, PC 0 -> 1
        step();
        ir_enable = 1; pc_enable = 1; data_in = 16'h8103;
        push("fetch_addr_old_pc", K_ADDR, 16'd0);
        step();
        push("fetch_dec", K_DEC, 16'(I_LOAD));
        push("fetch_pc", K_ADDR, 16'd1);
        step();
        addr_sel = 1;
        push("fetch_ir_addr", K_ADDR, 16'd3);

        // LOAD R1 = 1234 via IR 8123
        load_ir(16'h8123);
        step();
        addr_sel = 1; write_reg_enable = 1; data_in = 16'h1234;
        push("load_addr", K_ADDR, 16'd3);
        expect_reg("load_r1", 2'd1, 16'h1234);

        // ADD R2 = 7FFF + 0001
        write_reg(2'd0, 16'h7FFF);
        write_reg(2'd1, 16'h0001);
        alu_op(16'hA121, ALU_ADD);
        step();
        push_flags("add_ovf", 0, 1, 0, 1);
        expect_reg("add_r2", 2'd2, 16'h8000);
        push_flags("add_hold", 0, 1, 0, 1);

        // SUB R3 = 0000 - 0001, then 0 - 0
        write_reg(2'd0, 16'h0000);
        alu_op(16'hA231, ALU_SUB);
        step();
        push_flags("sub_borrow", 0, 1, 1, 0);
        expect_reg("sub_r3", 2'd3, 16'hFFFF);
        alu_op(16'hA230, ALU_SUB);
        step();
        push_flags("sub_equal", 1, 0, 0, 0);

        // ADD carry out: FFFF + 0001 = 0000
        write_reg(2'd0, 16'hFFFF);
        alu_op(16'hA121, ALU_ADD);
        step();
        push_flags("add_carry", 1, 0, 1, 0);
        expect_reg("add_carry_r2", 2'd2, 16'h0000);

        // MOVE R2 <- R1 with operation OR
        write_reg(2'd1, 16'h5A5A);
        alu_op(16'h9109, ALU_OR);
        step();
        push_flags("move", 0, 0, 0, 0);
        expect_reg("move_r2", 2'd2, 16'h5A5A);

        // SUB signed overflow: 8000 - 0001
        write_reg(2'd0, 16'h8000);
        write_reg(2'd1, 16'h0001);
        alu_op(16'hA231, ALU_SUB);
        step();
        push_flags("sub_sovf", 0, 0, 0, 1);
        expect_reg("sub_sovf_r3", 2'd3, 16'h7FFF);

        // AND 8000 & 0001 = 0
        alu_op(16'hA331, ALU_AND);
        step();
        push_flags("and", 1, 0, 0, 0);

        // Branch to 30, ignored branch, then increments with wrap (PC is 1)
        load_ir(16'h011E);
        step();
        pc_enable = 1; branch = 1;
        push("br_old_pc", K_ADDR, 16'd1);
        step();
        branch = 1;
        push("br_pc30", K_ADDR, 16'd30);
        step();
        pc_enable = 1;
        push("br_hold", K_ADDR, 16'd30);
        step();
        pc_enable = 1;
        push("inc_pc31", K_ADDR, 16'd31);
        step();
        push("wrap_pc0", K_ADDR, 16'd0);

        // STORE R2 = ABCD to address 5
        write_reg(2'd2, 16'hABCD);
        load_ir(16'h8245);
        step();
        addr_sel = 1;
        push("store_addr", K_ADDR, 16'd5);
        push("store_dout", K_DOUT, 16'hABCD);
        push("store_dec", K_DEC, 16'(I_STORE));

        // Same-cycle write and read of R2: old value visible
        load_ir(16'hA129);
        step();
        c_sel = 1; write_reg_enable = 1; operation = ALU_ADD;
        push("nobypass_old", K_DOUT, 16'hABCD);
        step();
        push("nobypass_new", K_DOUT, 16'hABCE);
        push_flags("and_hold", 1, 0, 0, 0);

        // Unknown opcode and HALT
        load_ir(16'h5500);
        step();
        push("unk_dec", K_DEC, 16'(I_NOP));
        push("unk_dout_r0", K_DOUT, 16'h8000);
        load_ir(16'hFF00);
        step();
        push("halt_dec", K_DEC, 16'(I_HALT));

        // Asynchronous reset between edges
        load_ir(16'h0105);
        step();
        pc_enable = 1; branch = 1;
        step();
        push("pre_rst_pc", K_ADDR, 16'd5);
        step();
        ir_enable = 1; data_in = 16'h8245; addr_sel = 1; write_reg_enable = 1;
        #1 rst_n = 0;
        push("arst_addr", K_ADDR, 16'h0000);
        push("arst_dout", K_DOUT, 16'h0000);
        push("arst_dec",  K_DEC,  16'(I_NOP));
        push_flags("arst", 0, 0, 0, 0);
        step();
        rst_n = 1;
        push("post_rst_pc", K_ADDR, 16'd0);
        expect_reg("post_rst_r2", 2'd2, 16'h0000);

        step();
        step();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_path.md
# data_path

Execution datapath of the K&S 16-bit processor: program counter, instruction register, instruction decoder, 4×16 register file, ALU and flag registers. It sits beside the control unit. It consumes the control unit's enables and selects, and returns the decoded instruction and registered ALU flags. It addresses the 32×16 unified program/data RAM and exchanges data with it.

## Interface
- No parameters; widths fixed: data 16 bit, address 5 bit, 4 registers.
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- branch  in  1  PC load source: 1 = IR[4:0], 0 = PC+1
- pc_enable  in  1  PC update enable
- ir_enable  in  1  IR loads data_in
- write_reg_enable  in  1  register file write enable
- addr_sel  in  1  ram_addr source: 0 = PC, 1 = IR[4:0]
- c_sel  in  1  register write data: 1 = ALU result, 0 = data_in
- operation  in  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR
- flags_reg_enable  in  1  flag registers capture ALU flags
- decoded_instruction  out  decoded_instruction_type  combinational decode of IR
- zero_op, neg_op  out  1 each  registered zero / sign flags
- unsigned_overflow, signed_overflow  out  1 each  registered carry-borrow / two's-complement overflow flags
- ram_addr  out  5  RAM address
- data_out  out  16  RAM write data
- data_in  in  16  RAM read data (combinational read)

## Operation
- IR[15:8] opcode decode:
  - 8'h00 NOP, 8'h01 BRANCH, 8'h02 BZERO, 8'h03 BNZERO, 8'h04 BNEG, 8'h05 BNNEG, 8'h06 BOV, 8'h07 BNOV
  - 8'h81 LOAD, 8'h82 STORE, 8'h91 MOVE
  - 8'hA1 ADD, 8'hA2 SUB, 8'hA3 AND, 8'hA4 OR
  - 8'hFF HALT; any other value decodes to I_NOP
- Register-address fields:
  - LOAD: c = IR[6:5]
  - STORE: a = IR[6:5]
  - MOVE: c = IR[3:2], a = b = IR[1:0]; the control unit issues operation = OR, so the result equals the source
  - ALU ops: c = IR[5:4], a = IR[3:2], b = IR[1:0]
  - Other opcodes: all fields 0
- Memory address field IR[4:0] is used by LOAD, STORE and all branches.
- data_out = register[a], continuously.
- ALU: 17-bit ADD/SUB on zero-extended operands; result = low 16 bits.
  - unsigned_overflow: ADD = carry out; SUB = borrow (a < b unsigned).
  - signed_overflow: ADD = operands have equal signs and result sign differs; SUB = operand signs differ and result sign differs from a.
  - AND/OR: both overflow flags 0.
  - zero = (result == 0); neg = result[15].
- PC is 5 bits and wraps 31 → 0 on increment.

## Timing
- Reset: PC = 0, IR = 16'h0000 (decoded_instruction = I_NOP), all registers = 0, all four flags = 0.
  - ram_addr = 0; data_out = 0.
  - Asserting rst_n mid-instruction clears everything immediately, independent of clk.
- ram_addr, data_out, ALU result, decoded_instruction: combinational, same cycle as their inputs.
- PC, IR, register file, flags: update at the edge where their enable is high; visible the next cycle.
- ir_enable and pc_enable together: IR captures the word at the old PC, and the PC advances (or loads IR[4:0] if branch = 1). This is a single-cycle fetch.
- branch is ignored when pc_enable = 0.
- Register written and read in the same cycle: the read returns the old value (no bypass).
- Flags hold their value while flags_reg_enable = 0. Branch decisions in the control unit use the flags from the last enabled ALU op.

## Structure
- k_and_s_pkg, shared with the control unit:
  - decoded_instruction_type enum (I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT)
  - opcode constants
  - ALU operation constants
- Sub-module register_file: 4×16, two asynchronous read ports, one synchronous write port, asynchronous clear.

## Test plan
- Reset then one cycle with ir_enable = pc_enable = 1, data_in = 16'h8103 → IR = 8103, decoded_instruction = I_LOAD, PC = 1, ram_addr (addr_sel = 0) = 1.
- LOAD path: addr_sel = 1, c_sel = 0, write_reg_enable = 1, data_in = 16'h1234, IR = 16'h8123 → R1 = 1234, ram_addr = 3.
- ADD R2 = R0 + R1 with R0 = 7FFF, R1 = 0001, flags_reg_enable = 1 → R2 = 8000; next cycle neg = 1, signed_overflow = 1, unsigned_overflow = 0, zero = 0.
- SUB R3 = R0 − R1 with R0 = 0000, R1 = 0001 → R3 = FFFF, unsigned_overflow = 1, neg = 1, signed_overflow = 0. Repeat with equal operands → zero = 1.
- Branch: IR = 16'h011E, branch = 1, pc_enable = 1 → PC = 30. Then two increments → PC 31, then 0 (wrap).
- STORE: IR = 16'h8245, R2 = ABCD, addr_sel = 1 → ram_addr = 5, data_out = ABCD. Opcode 8'h55 → I_NOP. rst_n pulsed mid-operation → all state zero before the next edge.
